// File: rtl/ctrl_pipeline_seq.sv
// Pipeline sequencer: owns decode/reg/alu/wb valid and branch flags, issues or
// bubbles decode, freezes fetch around in-flight branches, redirects PC on resolve.
module ctrl_pipeline_seq #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             fetch_valid_i,
  input  logic             decode_is_branch_i,
  input  logic             reg_conflict_i,
  input  logic             branch_conflict_i,
  input  logic             wb_branch_taken_i,
  input  logic [PC_W-1:0]  wb_branch_target_i,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             reg_valid_o,
  output logic             alu_valid_o,
  output logic             wb_valid_o,
  output logic             state_reg_pc_branch_o,
  output logic             state_alu_pc_branch_o,
  output logic             state_wb_pc_branch_o,
  output logic             pc_load_o,
  output logic [PC_W-1:0]  pc_load_value_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] brwait_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_WAIT  = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dec_v;
  logic             r_reg_v, r_reg_br;
  logic             r_alu_v, r_alu_br;
  logic             r_wb_v,  r_wb_br;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_brwait_cnt;

  logic w_run;
  logic w_issue;
  logic w_br_fly;
  logic w_fetch_en;
  logic w_resolve;
  logic w_pc_load;
  logic w_stall;

  always_comb begin
    w_run       = (r_state == ST_RUN);
    w_issue     = r_dec_v && !reg_conflict_i && w_run;
    w_br_fly    = branch_conflict_i || (w_issue && decode_is_branch_i);
    w_fetch_en  = fetch_valid_i && (!r_dec_v || w_issue) && !w_br_fly && w_run;
    w_resolve   = r_wb_v && r_wb_br;
    w_pc_load   = w_resolve && wb_branch_taken_i;
    w_stall     = r_dec_v && !w_issue && w_run;

    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:      if (w_issue && decode_is_branch_i) w_state_nxt = ST_BR_WAIT;
      ST_BR_WAIT:  if (w_resolve) w_state_nxt = wb_branch_taken_i ? ST_REDIRECT : ST_RUN;
      ST_REDIRECT: w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state      <= ST_RUN;
      r_dec_v      <= 1'b0;
      r_reg_v      <= 1'b0;
      r_reg_br     <= 1'b0;
      r_alu_v      <= 1'b0;
      r_alu_br     <= 1'b0;
      r_wb_v       <= 1'b0;
      r_wb_br      <= 1'b0;
      r_stall_cnt  <= '0;
      r_brwait_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      // A stalled decode simply holds; the reg stage receives a bubble via w_issue=0.
      if (w_fetch_en)   r_dec_v <= 1'b1;
      else if (w_issue) r_dec_v <= 1'b0;
      r_reg_v  <= w_issue;
      r_reg_br <= w_issue && decode_is_branch_i;
      r_alu_v  <= r_reg_v;
      r_alu_br <= r_reg_br;
      r_wb_v   <= r_alu_v;
      r_wb_br  <= r_alu_br;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!w_run && (r_brwait_cnt != '1))
        r_brwait_cnt <= r_brwait_cnt + CNT_W'(1);
    end
  end

  assign fetch_en_o            = w_fetch_en;
  assign decode_en_o           = w_fetch_en;
  assign reg_valid_o           = r_reg_v;
  assign alu_valid_o           = r_alu_v;
  assign wb_valid_o            = r_wb_v;
  assign state_reg_pc_branch_o = r_reg_v && r_reg_br;
  assign state_alu_pc_branch_o = r_alu_v && r_alu_br;
  assign state_wb_pc_branch_o  = r_wb_v && r_wb_br;
  assign pc_load_o             = w_pc_load;
  assign pc_load_value_o       = w_pc_load ? wb_branch_target_i : '0;
  assign stall_cycles_o        = r_stall_cnt;
  assign brwait_cycles_o       = r_brwait_cnt;

endmodule

// File: tb/tb_ctrl_pipeline_seq.sv
// Directed bench for ctrl_pipeline_seq; a second instance with CNT_W=2 shares
// the stimulus to exercise counter saturation.
module tb_ctrl_pipeline_seq;

  localparam int unsigned PC_W = 32;

  logic            clk = 1'b0;
  logic            arstn;
  logic            fetch_valid_i;
  logic            decode_is_branch_i;
  logic            reg_conflict_i;
  logic            branch_conflict_i;
  logic            wb_branch_taken_i;
  logic [PC_W-1:0] wb_branch_target_i;

  logic            fetch_en_o, decode_en_o;
  logic            reg_valid_o, alu_valid_o, wb_valid_o;
  logic            st_reg_br, st_alu_br, st_wb_br;
  logic            pc_load_o;
  logic [PC_W-1:0] pc_load_value_o;
  logic [15:0]     stall_cycles_o, brwait_cycles_o;

  logic            s_fetch_en, s_decode_en, s_reg_v, s_alu_v, s_wb_v;
  logic            s_reg_br, s_alu_br, s_wb_br, s_pc_load;
  logic [PC_W-1:0] s_pc_val;
  logic [1:0]      s_stall, s_brwait;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  // Conflict unit stand-in: a branch is in flight whenever any later stage holds one.
  assign branch_conflict_i = st_reg_br | st_alu_br | st_wb_br;

  ctrl_pipeline_seq #(.PC_W(PC_W), .CNT_W(16)) u_dut (
    .clk(clk), .arstn(arstn), .fetch_valid_i(fetch_valid_i),
    .decode_is_branch_i(decode_is_branch_i), .reg_conflict_i(reg_conflict_i),
    .branch_conflict_i(branch_conflict_i), .wb_branch_taken_i(wb_branch_taken_i),
    .wb_branch_target_i(wb_branch_target_i), .fetch_en_o(fetch_en_o),
    .decode_en_o(decode_en_o), .reg_valid_o(reg_valid_o), .alu_valid_o(alu_valid_o),
    .wb_valid_o(wb_valid_o), .state_reg_pc_branch_o(st_reg_br),
    .state_alu_pc_branch_o(st_alu_br), .state_wb_pc_branch_o(st_wb_br),
    .pc_load_o(pc_load_o), .pc_load_value_o(pc_load_value_o),
    .stall_cycles_o(stall_cycles_o), .brwait_cycles_o(brwait_cycles_o)
  );

  ctrl_pipeline_seq #(.PC_W(PC_W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .arstn(arstn), .fetch_valid_i(fetch_valid_i),
    .decode_is_branch_i(decode_is_branch_i), .reg_conflict_i(reg_conflict_i),
    .branch_conflict_i(branch_conflict_i), .wb_branch_taken_i(wb_branch_taken_i),
    .wb_branch_target_i(wb_branch_target_i), .fetch_en_o(s_fetch_en),
    .decode_en_o(s_decode_en), .reg_valid_o(s_reg_v), .alu_valid_o(s_alu_v),
    .wb_valid_o(s_wb_v), .state_reg_pc_branch_o(s_reg_br),
    .state_alu_pc_branch_o(s_alu_br), .state_wb_pc_branch_o(s_wb_br),
    .pc_load_o(s_pc_load), .pc_load_value_o(s_pc_val),
    .stall_cycles_o(s_stall), .brwait_cycles_o(s_brwait)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid_i      = 1'b0;
    decode_is_branch_i = 1'b0;
    reg_conflict_i     = 1'b0;
    wb_branch_taken_i  = 1'b0;
    wb_branch_target_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    arstn = 1'b0;
    tick();
    tick();
    arstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    idle_inputs();
    fetch_valid_i = 1'b1;
    arstn = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (fetch_en_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_fetch_en_during: got %b expected 1", fetch_en_o);
    end
    tick();
    arstn = 1'b1;
    #1;
    flags = {reg_valid_o, alu_valid_o, wb_valid_o, st_reg_br, st_alu_br, st_wb_br,
             pc_load_o, decode_en_o};
    n_cmp++;
    if (flags !== 8'b0000_0001) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000001", flags);
    end
    n_cmp++;
    if (fetch_en_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_fetch_en_after: got %b expected 1", fetch_en_o);
    end
    n_cmp++;
    if (stall_cycles_o !== 16'd0 || brwait_cycles_o !== 16'd0 || pc_load_value_o !== '0) begin
      n_bad++;
      $display("FAIL reset_counters: got stall=%0d brwait=%0d pcval=%0h expected 0 0 0",
               stall_cycles_o, brwait_cycles_o, pc_load_value_o);
    end
  endtask

  task automatic test_straight_line();
    // {fetch_en, reg_v, alu_v, wb_v} per cycle; five fetches on cycles 0..4
    logic [3:0] exp_v [10] = '{4'b1000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                               4'b0111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fetch_valid_i = (i < 5);
      #1;
      got = {fetch_en_o, reg_valid_o, alu_valid_o, wb_valid_o};
      n_cmp++;
      if (got !== exp_v[i]) begin
        n_bad++; $display("FAIL straight_c%0d: got %b expected %b", i, got, exp_v[i]);
      end
      tick();
    end
    n_cmp++;
    if (stall_cycles_o !== 16'd0) begin
      n_bad++; $display("FAIL straight_stall: got %0d expected 0", stall_cycles_o);
    end
  endtask

  task automatic test_reg_hazard();
    do_reset();
    fetch_valid_i = 1'b1;
    tick();
    reg_conflict_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (decode_en_o !== 1'b0 || reg_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL hazard_stall_c%0d: got decode_en=%b reg_v=%b expected 0 0",
                 i, decode_en_o, reg_valid_o);
      end
      tick();
    end
    reg_conflict_i = 1'b0;
    #1;
    n_cmp++;
    if (decode_en_o !== 1'b1 || reg_valid_o !== 1'b0 || stall_cycles_o !== 16'd2) begin
      n_bad++;
      $display("FAIL hazard_release: got decode_en=%b reg_v=%b stall=%0d expected 1 0 2",
               decode_en_o, reg_valid_o, stall_cycles_o);
    end
    tick();
    fetch_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (reg_valid_o !== 1'b1 || stall_cycles_o !== 16'd2) begin
      n_bad++;
      $display("FAIL hazard_issue: got reg_v=%b stall=%0d expected 1 2",
               reg_valid_o, stall_cycles_o);
    end
  endtask

  // Branch issued at cycle t; taken selects redirect path. Fetch stays requested.
  task automatic run_branch(input logic taken);
    logic [3:0] exp_br [6] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0000};
    logic [3:0] got;
    logic       exp_fe;
    logic       exp_pl;
    do_reset();
    fetch_valid_i      = 1'b1;
    wb_branch_taken_i  = taken;
    wb_branch_target_i = 32'h0000_0400;
    tick();
    for (int k = 0; k < 6; k++) begin
      decode_is_branch_i = (k == 0);
      #1;
      exp_pl = taken && (k == 3);
      exp_fe = taken ? (k == 5) : (k >= 4);
      got = {st_reg_br, st_alu_br, st_wb_br, exp_br[k][0]};
      n_cmp++;
      if ({st_reg_br, st_alu_br, st_wb_br} !== exp_br[k][3:1]) begin
        n_bad++;
        $display("FAIL branch%0b_flags_t+%0d: got %b expected %b",
                 taken, k, got[3:1], exp_br[k][3:1]);
      end
      n_cmp++;
      if (pc_load_o !== exp_pl || pc_load_value_o !== (exp_pl ? 32'h400 : 32'h0)) begin
        n_bad++;
        $display("FAIL branch%0b_pcload_t+%0d: got %b/%0h expected %b/%0h", taken, k,
                 pc_load_o, pc_load_value_o, exp_pl, exp_pl ? 32'h400 : 32'h0);
      end
      n_cmp++;
      if (fetch_en_o !== exp_fe) begin
        n_bad++;
        $display("FAIL branch%0b_fetch_t+%0d: got %b expected %b", taken, k, fetch_en_o, exp_fe);
      end
      if (k == (taken ? 5 : 4)) begin
        n_cmp++;
        if (brwait_cycles_o !== (taken ? 16'd4 : 16'd3)) begin
          n_bad++;
          $display("FAIL branch%0b_brwait: got %0d expected %0d", taken, brwait_cycles_o,
                   taken ? 4 : 3);
        end
      end
      tick();
    end
  endtask

  task automatic test_taken_branch();
    run_branch(1'b1);
  endtask

  task automatic test_not_taken_branch();
    run_branch(1'b0);
  endtask

  task automatic test_conflict_on_branch();
    do_reset();
    fetch_valid_i = 1'b1;
    tick();
    decode_is_branch_i = 1'b1;
    reg_conflict_i     = 1'b1;
    #1;
    n_cmp++;
    if (fetch_en_o !== 1'b0) begin
      n_bad++; $display("FAIL brconf_fetch: got %b expected 0", fetch_en_o);
    end
    tick();
    reg_conflict_i = 1'b0;
    #1;
    n_cmp++;
    if (st_reg_br !== 1'b0 || stall_cycles_o !== 16'd1 || brwait_cycles_o !== 16'd0) begin
      n_bad++;
      $display("FAIL brconf_hold: got reg_br=%b stall=%0d brwait=%0d expected 0 1 0",
               st_reg_br, stall_cycles_o, brwait_cycles_o);
    end
    tick();
    decode_is_branch_i = 1'b0;
    #1;
    n_cmp++;
    if (st_reg_br !== 1'b1 || fetch_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL brconf_issue: got reg_br=%b fetch_en=%b expected 1 0", st_reg_br, fetch_en_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    fetch_valid_i = 1'b1;
    tick();
    reg_conflict_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    reg_conflict_i = 1'b0;
    fetch_valid_i  = 1'b0;
    #1;
    n_cmp++;
    if (s_stall !== 2'd3) begin
      n_bad++; $display("FAIL sat_stall_cnt2: got %0d expected 3", s_stall);
    end
    n_cmp++;
    if (stall_cycles_o !== 16'd5) begin
      n_bad++; $display("FAIL sat_stall_cnt16: got %0d expected 5", stall_cycles_o);
    end
  endtask

  task automatic test_midflight_reset();
    logic [6:0] flags;
    do_reset();
    fetch_valid_i      = 1'b1;
    wb_branch_taken_i  = 1'b1;
    wb_branch_target_i = 32'h0000_0400;
    tick();
    decode_is_branch_i = 1'b1;
    tick();
    decode_is_branch_i = 1'b0;
    tick();
    arstn = 1'b0;
    #1;
    n_cmp++;
    if (st_alu_br !== 1'b1) begin
      n_bad++; $display("FAIL midreset_pre_alu_br: got %b expected 1", st_alu_br);
    end
    tick();
    #1;
    flags = {reg_valid_o, alu_valid_o, wb_valid_o, st_reg_br, st_alu_br, st_wb_br, pc_load_o};
    n_cmp++;
    if (flags !== 7'b0 || brwait_cycles_o !== 16'd0 || fetch_en_o !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_cleared: got flags=%b brwait=%0d fetch_en=%b expected 0000000 0 1",
               flags, brwait_cycles_o, fetch_en_o);
    end
    arstn = 1'b1;
    tick();
    fetch_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (pc_load_o !== 1'b0 || st_wb_br !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_no_redirect: got pc_load=%b wb_br=%b expected 0 0", pc_load_o, st_wb_br);
    end
  endtask

  initial begin
    arstn = 1'b0;
    idle_inputs();
    test_reset();
    test_straight_line();
    test_reg_hazard();
    test_taken_branch();
    test_not_taken_branch();
    test_conflict_on_branch();
    test_saturation();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
